alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Issues one operation at a time to an external ALU with a
//                fixed latency. It registers the operands, waits ALU_LAT
//                cycles, captures the result and flags, and then holds them
//                until the consumer accepts. The completed-operation counter
//                wraps at 8 bits.
//                Optional macro ALU_OP_SEQUENCER_CHAIN_EN adds a req_chain
//                input. When it is set, operand a is taken from the last
//                captured result.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_op_sequencer #(
   parameter int ALU_LAT = 1              // legal 1..15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   input  logic [3:0] req_sel,
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
   input  logic       req_chain,
`endif
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_sel,
   input  logic [7:0] alu_out,
   input  logic [4:0] alu_flags,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_out,
   output logic [4:0] rsp_flags,
   output logic       busy,
   output logic [7:0] op_count
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_WAIT   = 2'd1;
   localparam logic [1:0] c_RESP   = 2'd2;
   localparam logic [3:0] c_LAT_M1 = 4'(ALU_LAT - 1);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [3:0] r_cnt;
   logic [7:0] r_alu_a;
   logic [7:0] r_alu_b;
   logic [3:0] r_alu_sel;
   logic [7:0] r_rsp_out;
   logic [4:0] r_rsp_flags;
   logic [7:0] r_op_count;
   logic [7:0] w_a_src;
   logic       w_accept;
   logic       w_capture;
   logic       w_release;

   // Operand a source: the previous result when chaining, otherwise the request
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
   assign w_a_src = req_chain ? r_rsp_out : req_a;
`else
   assign w_a_src = req_a;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; WAIT exits on the edge where the counter reads zero
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (req_valid)     w_state_nxt = c_WAIT;
         c_WAIT:  if (r_cnt == 4'd0) w_state_nxt = c_RESP;
         c_RESP:  if (rsp_ready)     w_state_nxt = c_IDLE;
         default:                    w_state_nxt = c_IDLE;
      endcase
   end

   // State-decoded handshakes and datapath enables
   always_comb begin
      req_ready = (r_state == c_IDLE);
      rsp_valid = (r_state == c_RESP);
      busy      = (r_state != c_IDLE);
      w_accept  = (r_state == c_IDLE) && req_valid;
      w_capture = (r_state == c_WAIT) && (r_cnt == 4'd0);
      w_release = (r_state == c_RESP) && rsp_ready;
   end

   // Latency counter: preset on accept, count down while waiting
   always_ff @(posedge clk) begin
      if (rst)                               r_cnt <= 4'd0;
      else if (w_accept)                     r_cnt <= c_LAT_M1;
      else if ((r_state == c_WAIT) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
   end

   // Operand registers: load on accept, hold otherwise (including after completion)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_a   <= 8'h00;
         r_alu_b   <= 8'h00;
         r_alu_sel <= 4'h0;
      end else if (w_accept) begin
         r_alu_a   <= w_a_src;
         r_alu_b   <= req_b;
         r_alu_sel <= req_sel;
      end
   end

   // Response capture: sample ALU result/flags once, hold through any stall
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_out   <= 8'h00;
         r_rsp_flags <= 5'b00000;
      end else if (w_capture) begin
         r_rsp_out   <= alu_out;
         r_rsp_flags <= alu_flags;
      end
   end

   // Completed-operation counter, wraps naturally at 8 bits
   always_ff @(posedge clk) begin
      if (rst)            r_op_count <= 8'h00;
      else if (w_release) r_op_count <= r_op_count + 8'h01;
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_sel   = r_alu_sel;
   assign rsp_out   = r_rsp_out;
   assign rsp_flags = r_rsp_flags;
   assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Self-checking bench for alu_op_sequencer. It instantiates
//                two DUTs, with ALU_LAT=1 and ALU_LAT=3, each driven by a
//                stub ALU. Expected responses are queued at issue time and
//                compared when each response is delivered.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_op_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       req_valid [2];
   logic       req_ready [2];
   logic [7:0] req_a     [2];
   logic [7:0] req_b     [2];
   logic [3:0] req_sel   [2];
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
   logic       req_chain [2];
`endif
   logic [7:0] alu_a     [2];
   logic [7:0] alu_b     [2];
   logic [3:0] alu_sel   [2];
   logic       rsp_valid [2];
   logic       rsp_ready [2];
   logic [7:0] rsp_out   [2];
   logic [4:0] rsp_flags [2];
   logic       busy      [2];
   logic [7:0] op_count  [2];

   // Stub ALU controls: override forces a fixed result/flags
   logic       ovr_en    [2];
   logic [7:0] ovr_out   [2];
   logic [4:0] ovr_flags [2];

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   logic [12:0] exp_q [$];
   logic [7:0] exp_cnt  [2];
   logic [7:0] last_rsp [2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] stub_out(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s);
      return (a + b) ^ {s, s};
   endfunction

   function automatic logic [4:0] stub_flags(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] s, input logic [7:0] o);
      return {s[3] ^ o[0], a[7], b[7], o[7], ^o};
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int LAT = (k == 0) ? 1 : 3;
      logic [7:0] w_out;
      logic [4:0] w_flags;
      assign w_out   = ovr_en[k] ? ovr_out[k]
                                 : stub_out(alu_a[k], alu_b[k], alu_sel[k]);
      assign w_flags = ovr_en[k] ? ovr_flags[k]
                                 : stub_flags(alu_a[k], alu_b[k], alu_sel[k], w_out);
      alu_op_sequencer #(.ALU_LAT(LAT)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[k]),
         .req_ready (req_ready[k]),
         .req_a     (req_a[k]),
         .req_b     (req_b[k]),
         .req_sel   (req_sel[k]),
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
         .req_chain (req_chain[k]),
`endif
         .alu_a     (alu_a[k]),
         .alu_b     (alu_b[k]),
         .alu_sel   (alu_sel[k]),
         .alu_out   (w_out),
         .alu_flags (w_flags),
         .rsp_valid (rsp_valid[k]),
         .rsp_ready (rsp_ready[k]),
         .rsp_out   (rsp_out[k]),
         .rsp_flags (rsp_flags[k]),
         .busy      (busy[k]),
         .op_count  (op_count[k])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         exp_cnt[k]  = 8'h00;
         last_rsp[k] = 8'h00;
      end
   endtask

   // One complete operation: issue, latency check, optional stall, retire.
   // o_out2 replaces the override value just before the capture edge.
   task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] sel, input logic chain, input int stall,
                        input logic use_ovr, input logic [7:0] o_out,
                        input logic [7:0] o_out2, input logic [4:0] o_fl,
                        output int acc_cyc);
      int          lat;
      int          cnt;
      logic [7:0]  ea;
      logic [7:0]  eo;
      logic [4:0]  ef;
      logic [12:0] e;
      logic [7:0]  hold_out;
      logic [4:0]  hold_fl;
      lat = (k == 0) ? 1 : 3;
      ea  = a;
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
      req_chain[k] = chain;
      if (chain) ea = last_rsp[k];
`else
      if (chain) ea = a;
`endif
      check_eq("pre_ready", req_ready[k], 1);
      req_a[k] = a; req_b[k] = b; req_sel[k] = sel; req_valid[k] = 1'b1;
      ovr_en[k] = use_ovr; ovr_out[k] = o_out; ovr_flags[k] = o_fl;
      @(posedge clk);
      acc_cyc = cyc;
      #1;
      req_valid[k] = 1'b0;
      req_a[k] = 8'($urandom); req_b[k] = 8'($urandom);
      eo = use_ovr ? o_out2 : stub_out(ea, b, sel);
      ef = use_ovr ? o_fl   : stub_flags(ea, b, sel, eo);
      exp_q.push_back({eo, ef});
      check_eq("alu_a", alu_a[k], ea);
      check_eq("alu_b", alu_b[k], b);
      check_eq("alu_sel", alu_sel[k], sel);
      check_eq("busy_wait", busy[k], 1);
      cnt = 0;
      if (lat == 1) ovr_out[k] = o_out2;
      while (!rsp_valid[k] && cnt < 20) begin
         @(posedge clk); #1; cnt++;
         if (cnt == lat - 1) ovr_out[k] = o_out2;
      end
      check_eq("latency", cnt, lat);
      e = exp_q.pop_front();
      if (!rsp_valid[k]) return;
      hold_out = rsp_out[k];
      hold_fl  = rsp_flags[k];
      for (int i = 0; i < stall; i++) begin
         req_valid[k] = 1'b1;
         @(posedge clk); #1;
         check_eq("stall_valid", rsp_valid[k], 1);
         check_eq("stall_out", rsp_out[k], hold_out);
         check_eq("stall_flags", rsp_flags[k], hold_fl);
         check_eq("stall_rdy", req_ready[k], 0);
      end
      check_eq("rsp_out", rsp_out[k], e[12:5]);
      check_eq("rsp_flags", rsp_flags[k], e[4:0]);
      check_eq("alu_a_hold", alu_a[k], ea);
      last_rsp[k] = e[12:5];
      exp_cnt[k]  = exp_cnt[k] + 8'h01;
      rsp_ready[k] = 1'b1;
      req_valid[k] = 1'b1;                   // must not be taken on the release edge
      @(posedge clk); #1;
      rsp_ready[k] = 1'b0;
      req_valid[k] = 1'b0;
      check_eq("op_count", op_count[k], exp_cnt[k]);
      check_eq("idle_ready", req_ready[k], 1);
      check_eq("idle_valid", rsp_valid[k], 0);
      check_eq("no_accept_on_release", alu_a[k], ea);
   endtask

   initial begin
      int acc;
      int prev;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0; req_a[k] = 8'h00; req_b[k] = 8'h00; req_sel[k] = 4'h0;
         rsp_ready[k] = 1'b0; ovr_en[k] = 1'b0; ovr_out[k] = 8'h00; ovr_flags[k] = 5'h00;
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
         req_chain[k] = 1'b0;
`endif
      end
      do_reset();

      // Reset state of both instances
      for (int k = 0; k < 2; k++) begin
         check_eq("rst_busy", busy[k], 0);
         check_eq("rst_req_ready", req_ready[k], 1);
         check_eq("rst_rsp_valid", rsp_valid[k], 0);
         check_eq("rst_alu_a", alu_a[k], 8'h00);
         check_eq("rst_alu_b", alu_b[k], 8'h00);
         check_eq("rst_alu_sel", alu_sel[k], 4'h0);
         check_eq("rst_rsp_out", rsp_out[k], 8'h00);
         check_eq("rst_rsp_flags", rsp_flags[k], 5'h00);
         check_eq("rst_op_count", op_count[k], 8'h00);
      end

      // Reset in the middle of WAIT on the latency-3 instance
      req_a[1] = 8'h5A; req_b[1] = 8'hA5; req_sel[1] = 4'h7; req_valid[1] = 1'b1;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      check_eq("midwait_busy", busy[1], 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("wrst_busy", busy[1], 0);
      check_eq("wrst_req_ready", req_ready[1], 1);
      check_eq("wrst_rsp_valid", rsp_valid[1], 0);
      check_eq("wrst_alu_a", alu_a[1], 8'h00);
      check_eq("wrst_op_count", op_count[1], 8'h00);

      // Fixed-value transaction at latency 1
      do_op(0, 8'h0A, 8'h8F, 4'h0, 1'b0, 0, 1'b1, 8'h99, 8'h99, 5'b10101, acc);
      // Result changes one edge before capture at latency 3
      do_op(1, 8'h12, 8'h34, 4'h5, 1'b0, 0, 1'b1, 8'h11, 8'h22, 5'b01100, acc);
      // Ten-cycle consumer stall
      do_op(0, 8'h55, 8'hAA, 4'h3, 1'b0, 10, 1'b0, 8'h00, 8'h00, 5'h00, acc);
`ifdef ALU_OP_SEQUENCER_CHAIN_EN
      do_op(0, 8'h01, 8'h02, 4'h1, 1'b0, 0, 1'b1, 8'h3C, 8'h3C, 5'b00110, acc);
      do_op(0, 8'hFF, 8'h01, 4'h2, 1'b1, 0, 1'b0, 8'h00, 8'h00, 5'h00, acc);
`endif
      for (int i = 0; i < 4; i++)
         do_op(1, 8'($urandom), 8'($urandom), 4'($urandom), 1'b0, i, 1'b0,
               8'h00, 8'h00, 5'h00, acc);

      // Reset during RESP discards the response and clears the counter
      req_a[0] = 8'h21; req_b[0] = 8'h43; req_sel[0] = 4'h1; req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      check_eq("midresp_valid", rsp_valid[0], 1);
      rst = 1'b1; rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; rsp_ready[0] = 1'b0;
      exp_cnt[0] = 8'h00; exp_cnt[1] = 8'h00; last_rsp[0] = 8'h00; last_rsp[1] = 8'h00;
      check_eq("rrst_valid", rsp_valid[0], 0);
      check_eq("rrst_rsp_out", rsp_out[0], 8'h00);
      check_eq("rrst_rsp_flags", rsp_flags[0], 5'h00);
      check_eq("rrst_op_count", op_count[0], 8'h00);
      check_eq("rrst_alu_sel", alu_sel[0], 4'h0);

      // 256 back-to-back operations: counter wraps, fixed issue interval
      prev = 0;
      for (int i = 0; i < 256; i++) begin
         do_op(0, 8'($urandom), 8'($urandom), 4'($urandom), 1'b0, 0, 1'b0,
               8'h00, 8'h00, 5'h00, acc);
         if (i > 0) check_eq("issue_interval", acc - prev, 3);
         prev = acc;
      end
      check_eq("wrap_op_count", op_count[0], 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time limit so the run always terminates
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
